mc_sequencer: RTL and testbench



---
 rtl/mc_pkg.sv | 45 ++++
 rtl/mc_wait_timer.sv | 31 +++
 rtl/mc_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_mc_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control sequencer.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPE_EX,
    S_ALU_WB, S_ADDI_EX, S_BRANCH, S_JUMP, S_JAL, S_JR, S_HALT
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REGA   = 2'd3;

  localparam logic [1:0] SRCB_REGB    = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH  = 2'd3;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] DST_RT       = 2'd0;
  localparam logic [1:0] DST_RD       = 2'd1;
  localparam logic [1:0] DST_LINK     = 2'd2;

  localparam logic [1:0] M2R_ALU      = 2'd0;
  localparam logic [1:0] M2R_MEM      = 2'd1;
  localparam logic [1:0] M2R_PC       = 2'd2;

  // States that hold a memory access open and are subject to the wait timeout.
  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags a timeout.
module mc_wait_timer #(
  parameter int WAIT_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic busy_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i)                cnt_d = '0;
    else if (busy_i && !ready_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Fires on the WAIT_LIMIT-th not-ready cycle so the FSM leaves on that edge.
  assign timeout_o = busy_i && !ready_i && (cnt_q == CW'(WAIT_LIMIT - 1));

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle MIPS control FSM: drives datapath selects/enables per step,
// handles memory handshake with timeout, and counts retired instructions.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int COUNT_W    = 16,
  parameter int LINK_REG   = 15,
  parameter int WAIT_LIMIT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic [1:0]         pc_src,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               fault,
  output logic [COUNT_W-1:0] retired
);

  if (LINK_REG < 0 || LINK_REG > 31) begin : g_bad_link
    $error("LINK_REG must address one of 32 registers");
  end

  state_e               state_q, state_d;
  logic                 dst_rd_q, dst_rd_d;
  logic                 fault_q, fault_d;
  logic [COUNT_W-1:0]   retired_q, retired_d;
  logic                 timeout, wt_start;

  mc_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait (
    .clk       (clk),
    .reset     (reset),
    .start_i   (wt_start),
    .busy_i    (is_mem_state(state_q)),
    .ready_i   (mem_ready),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d    = state_q;
    dst_rd_d   = dst_rd_q;
    fault_d    = fault_q;
    pc_en      = 1'b0;
    pc_src     = PCSRC_ALU;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    alu_op     = ALUOP_ADD;
    reg_write  = 1'b0;
    reg_dst    = DST_RT;
    mem_to_reg = M2R_ALU;

    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (timeout)        begin state_d = S_HALT; fault_d = 1'b1; end
        else if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = (funct == FN_JR) ? S_JR : S_RTYPE_EX;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          default:      begin state_d = S_HALT; fault_d = 1'b1; end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (timeout)        begin state_d = S_HALT; fault_d = 1'b1; end
        else if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MEM;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (timeout)        begin state_d = S_HALT; fault_d = 1'b1; end
        else if (mem_ready) state_d = S_FETCH;
      end
      S_RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        dst_rd_d  = 1'b1;
        state_d   = S_ALU_WB;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        dst_rd_d  = 1'b0;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = dst_rd_q ? DST_RD : DST_RT;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_en     = zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = PCSRC_JUMP;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        pc_src     = PCSRC_JUMP;
        pc_en      = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = DST_LINK;
        mem_to_reg = M2R_PC;
        state_d    = S_FETCH;
      end
      S_JR: begin
        pc_src  = PCSRC_REGA;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // Outputs must fall the moment reset rises, not at the next edge.
    if (reset) begin
      pc_en      = 1'b0;
      pc_src     = '0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = '0;
      alu_op     = '0;
      reg_write  = 1'b0;
      reg_dst    = '0;
      mem_to_reg = '0;
    end
  end

  assign wt_start  = (state_d != state_q) && is_mem_state(state_d);
  assign retired_d = (state_d == S_FETCH && state_q != S_FETCH) ? retired_q + 1'b1 : retired_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      dst_rd_q  <= 1'b0;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      dst_rd_q  <= dst_rd_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: per-cycle control vectors against hand-derived values.
module tb_mc_sequencer;

  localparam int COUNT_W = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [5:0]         opcode = 6'h00, funct = 6'h00;
  logic               zero = 1'b0, mem_ready = 1'b0;
  logic               pc_en, ir_write, mem_read, mem_write, i_or_d, alu_src_a, reg_write, fault;
  logic [1:0]         pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg;
  logic [COUNT_W-1:0] retired;

  mc_sequencer #(.COUNT_W(COUNT_W), .LINK_REG(15), .WAIT_LIMIT(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .pc_src(pc_src), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, exp_ret = 0;

  // {pc_en,pc_src,ir_write,mem_read,mem_write,i_or_d,alu_src_a,alu_src_b,alu_op,reg_write,reg_dst,mem_to_reg}
  localparam logic [16:0] E_IDLE     = '0;
  localparam logic [16:0] E_FETCH    = {1'b1,2'd0,1'b1,1'b1,1'b0,1'b0,1'b0,2'd1,2'd0,1'b0,2'd0,2'd0};
  localparam logic [16:0] E_FETCH_W  = {1'b0,2'd0,1'b0,1'b1,1'b0,1'b0,1'b0,2'd1,2'd0,1'b0,2'd0,2'd0};
  localparam logic [16:0] E_DECODE   = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,2'd0,1'b0,2'd0,2'd0};
  localparam logic [16:0] E_MEMADR   = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd0,1'b0,2'd0,2'd0};
  localparam logic [16:0] E_MEMRD    = {1'b0,2'd0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,2'd0,1'b0,2'd0,2'd0};
  localparam logic [16:0] E_MEMWB    = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd0,2'd1};
  localparam logic [16:0] E_MEMWR    = {1'b0,2'd0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,2'd0,1'b0,2'd0,2'd0};
  localparam logic [16:0] E_RTYPE    = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd2,1'b0,2'd0,2'd0};
  localparam logic [16:0] E_ADDI     = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd0,1'b0,2'd0,2'd0};
  localparam logic [16:0] E_ALUWB_RD = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd1,2'd0};
  localparam logic [16:0] E_ALUWB_RT = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd0,2'd0};
  localparam logic [16:0] E_BEQ_T    = {1'b1,2'd1,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd1,1'b0,2'd0,2'd0};
  localparam logic [16:0] E_BEQ_N    = {1'b0,2'd1,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd1,1'b0,2'd0,2'd0};
  localparam logic [16:0] E_JUMP     = {1'b1,2'd2,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,2'd0,2'd0};
  localparam logic [16:0] E_JAL      = {1'b1,2'd2,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd2,2'd2};
  localparam logic [16:0] E_JR       = {1'b1,2'd3,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,2'd0,2'd0};

  function automatic logic [16:0] obs_vec();
    return {pc_en, pc_src, ir_write, mem_read, mem_write, i_or_d, alu_src_a,
            alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg};
  endfunction

  // Called at a negedge: apply mem_ready, sample the cycle's outputs, advance one cycle.
  task automatic cyc(input logic rdy, output logic [16:0] obs);
    mem_ready = rdy;
    #1 obs = obs_vec();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_ret = 0;
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if (obs_vec() !== E_IDLE) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs_vec(), E_IDLE); end
    n_chk++;
    if (retired !== '0 || fault !== 1'b0) begin n_fail++; $display("FAIL reset_regs: retired %0d fault %b expected 0 0", retired, fault); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    logic [16:0] exp [4] = '{E_FETCH, E_DECODE, E_RTYPE, E_ALUWB_RD};
    logic [16:0] obs;
    opcode = 6'h00; funct = 6'h20;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, obs); n_chk++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL rtype cyc%0d: got %h expected %h", i, obs, exp[i]); end
    end
    exp_ret++; n_chk++;
    if (retired !== COUNT_W'(exp_ret)) begin n_fail++; $display("FAIL rtype_retired: got %0d expected %0d", retired, exp_ret); end
  endtask

  task automatic test_lw_wait();
    logic [16:0] exp [7] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMWB};
    logic        rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [16:0] obs;
    opcode = 6'h23; funct = 6'h00;
    for (int i = 0; i < 7; i++) begin
      cyc(rdy[i], obs); n_chk++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL lw_wait cyc%0d: got %h expected %h", i, obs, exp[i]); end
    end
    exp_ret++; n_chk++;
    if (retired !== COUNT_W'(exp_ret)) begin n_fail++; $display("FAIL lw_retired: got %0d expected %0d", retired, exp_ret); end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp [9] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_MEMWR,
                             E_FETCH, E_DECODE, E_ADDI, E_ALUWB_RT};
    logic        rdy [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [16:0] obs;
    funct = 6'h20;
    for (int i = 0; i < 9; i++) begin
      opcode = (i < 5) ? 6'h2B : 6'h08;
      cyc(rdy[i], obs); n_chk++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL sw_addi cyc%0d: got %h expected %h", i, obs, exp[i]); end
    end
    exp_ret += 2; n_chk++;
    if (retired !== COUNT_W'(exp_ret)) begin n_fail++; $display("FAIL sw_addi_retired: got %0d expected %0d", retired, exp_ret); end
  endtask

  task automatic test_beq();
    logic [16:0] obs, e;
    opcode = 6'h04; funct = 6'h00;
    for (int z = 1; z >= 0; z--) begin
      zero = (z == 1);
      for (int i = 0; i < 3; i++) begin
        e = (i == 0) ? E_FETCH : (i == 1) ? E_DECODE : (z == 1) ? E_BEQ_T : E_BEQ_N;
        cyc(1'b1, obs); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL beq_z%0d cyc%0d: got %h expected %h", z, i, obs, e); end
      end
      exp_ret++; n_chk++;
      if (retired !== COUNT_W'(exp_ret)) begin n_fail++; $display("FAIL beq_retired: got %0d expected %0d", retired, exp_ret); end
    end
    zero = 1'b0;
  endtask

  task automatic test_jal_jr();
    logic [16:0] exp [6] = '{E_FETCH, E_DECODE, E_JAL, E_FETCH, E_DECODE, E_JR};
    logic [16:0] obs;
    for (int i = 0; i < 6; i++) begin
      opcode = (i < 3) ? 6'h03 : 6'h00;
      funct  = 6'h08;
      cyc(1'b1, obs); n_chk++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL jal_jr cyc%0d: got %h expected %h", i, obs, exp[i]); end
    end
    exp_ret += 2; n_chk++;
    if (retired !== COUNT_W'(exp_ret)) begin n_fail++; $display("FAIL jal_jr_retired: got %0d expected %0d", retired, exp_ret); end
  endtask

  task automatic test_illegal();
    logic [16:0] exp [5] = '{E_FETCH, E_DECODE, E_IDLE, E_IDLE, E_IDLE};
    logic [16:0] obs;
    opcode = 6'h3F; funct = 6'h00;
    for (int i = 0; i < 5; i++) begin
      cyc(i[0] | (i < 2), obs); n_chk++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL illegal cyc%0d: got %h expected %h", i, obs, exp[i]); end
    end
    n_chk++;
    if (fault !== 1'b1 || retired !== COUNT_W'(exp_ret)) begin
      n_fail++; $display("FAIL illegal_halt: fault %b retired %0d expected 1 %0d", fault, retired, exp_ret);
    end
  endtask

  task automatic test_fetch_timeout();
    logic [16:0] obs, e;
    logic        f;
    opcode = 6'h00; funct = 6'h20;
    for (int i = 0; i < 10; i++) begin
      f = fault;
      e = (i < 8) ? E_FETCH_W : E_IDLE;
      cyc(1'b0, obs); n_chk++;
      if (obs !== e || f !== (i >= 8)) begin
        n_fail++; $display("FAIL fetch_timeout cyc%0d: got %h fault %b expected %h fault %b", i, obs, f, e, (i >= 8));
      end
    end
    n_chk++;
    if (retired !== '0) begin n_fail++; $display("FAIL timeout_retired: got %0d expected 0", retired); end
  endtask

  task automatic test_reset_mid_sw();
    logic [16:0] exp [6] = '{E_FETCH, E_DECODE, E_JUMP, E_FETCH, E_DECODE, E_MEMADR};
    logic [16:0] obs;
    for (int i = 0; i < 6; i++) begin
      opcode = (i < 3) ? 6'h02 : 6'h2B;
      cyc(1'b1, obs); n_chk++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL mid_sw cyc%0d: got %h expected %h", i, obs, exp[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, obs); n_chk++;
      if (obs !== E_MEMWR) begin n_fail++; $display("FAIL mid_sw_wait cyc%0d: got %h expected %h", i, obs, E_MEMWR); end
    end
    n_chk++;
    if (retired !== 16'd1) begin n_fail++; $display("FAIL mid_sw_pre_retired: got %0d expected 1", retired); end
    #2 reset = 1'b1;
    #1; n_chk++;
    if (mem_write !== 1'b0 || obs_vec() !== E_IDLE) begin
      n_fail++; $display("FAIL mid_sw_async: mem_write %b vec %h expected 0 %h", mem_write, obs_vec(), E_IDLE);
    end
    @(negedge clk);
    reset = 1'b0; exp_ret = 0;
    cyc(1'b1, obs); n_chk++;
    if (obs !== E_FETCH || retired !== '0) begin
      n_fail++; $display("FAIL mid_sw_release: got %h retired %0d expected %h 0", obs, retired, E_FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_back_to_back();
    test_beq();
    test_jal_jr();
    test_illegal();
    do_reset();
    test_fetch_timeout();
    do_reset();
    test_reset_mid_sw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
